hm_hash_engine: RTL and testbench

- Bitcoin proof-of-work hashing engine.
- Takes an 80-byte block header, presented as two 512-bit pre-padded SHA-256 chunks selected by `hash_select`. Computes SHA256(SHA256(header)), compares the result against `difficulty`, and increments the nonce until a valid hash is found, `quit_hash` is asserted, or the nonce space is exhausted.
- Sits between the miner's header/work controller and its result reporting logic.

---
 rtl/hm_pkg.sv | 44 ++++
 rtl/hm_hash_engine_round.sv | 35 +++
 rtl/hm_hash_engine.sv | 172 +++++++++++++++++
 tb/tb_hm_hash_engine.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hm_pkg.sv
// Shared constants, FSM encoding and helpers for the double SHA-256 hash engine.
package hm_pkg;

  // SHA-256 round constants
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Initial hash value, H0 in the top word
  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  // Padding for the second hash: a 256-bit message in one block
  localparam logic [31:0] PAD_START = 32'h80000000;
  localparam logic [31:0] PAD_LEN   = 32'h00000100;

  typedef enum logic [3:0] {
    IDLE, LOAD1, RND1, UPD1, LOAD2, RND2, UPD2, LOAD3, RND3, UPD3, CHECK, DONE
  } state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[8*(31-i) +: 8];
    return r;
  endfunction

  // Word-wise modulo-2^32 addition of two 8-word states
  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

endpackage

// File: rtl/hm_hash_engine_round.sv
// One combinational SHA-256 compression round plus the next schedule word.
// State packing: a in [255:224] down to h in [31:0].
module sha256_round (
  input  logic [255:0] st_in,
  input  logic [31:0]  wt,
  input  logic [31:0]  kt,
  input  logic [31:0]  w_m15,
  input  logic [31:0]  w_m7,
  input  logic [31:0]  w_m2,
  output logic [255:0] st_out,
  output logic [31:0]  w_new
);

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] big_s0, big_s1, ch, maj, t1, t2, small_s0, small_s1;

  assign {a, b, c, d, e, f, g, h} = st_in;

  assign big_s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
  assign ch     = (e & f) ^ (~e & g);
  assign t1     = h + big_s1 + ch + kt + wt;
  assign big_s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
  assign maj    = (a & b) ^ (a & c) ^ (b & c);
  assign t2     = big_s0 + maj;
  assign st_out = {t1 + t2, a, b, c, d + t1, e, f, g};

  assign small_s0 = ror(w_m15, 7) ^ ror(w_m15, 18) ^ (w_m15 >> 3);
  assign small_s1 = ror(w_m2, 17) ^ ror(w_m2, 19) ^ (w_m2 >> 10);
  assign w_new    = small_s1 + w_m7 + small_s0 + wt;

endmodule

// File: rtl/hm_hash_engine.sv
// Bitcoin proof-of-work engine: double SHA-256 of an 80-byte header with a
// nonce search. Chunk 1 is hashed once into a midstate that every nonce
// attempt reuses; each attempt rehashes chunk 2 and then the first digest.
module hm_hash_engine
  import hm_pkg::*;
#(
  parameter int NONCE_WORD = 3
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         begin_hash,
  input  logic         quit_hash,
  input  logic [255:0] difficulty,
  input  logic [511:0] data_to_hash,
  output logic [1:0]   hash_select,
  output logic         valid_hash_flag,
  output logic [287:0] valid_hash,
  output logic         hash_done
);

  state_t         state_reg;
  logic [5:0]     round_reg;
  logic [31:0]    w_reg [16];
  logic [255:0]   work_reg;
  logic [255:0]   mid_reg;
  logic [255:0]   digest_reg;
  logic [31:0]    nonce_reg;
  logic           first_reg;

  logic [255:0]   st_next;
  logic [31:0]    w_new;
  logic [31:0]    chunk_word [16];
  logic [31:0]    pad_word [16];
  logic [31:0]    nonce_int;
  logic [31:0]    nonce_inc;
  logic           hash_ok;

  sha256_round u_round (
    .st_in  (work_reg),
    .wt     (w_reg[0]),
    .kt     (K[round_reg]),
    .w_m15  (w_reg[1]),
    .w_m7   (w_reg[9]),
    .w_m2   (w_reg[14]),
    .st_out (st_next),
    .w_new  (w_new)
  );

  // Block words: the incoming chunk (with the nonce substituted on retries)
  // and the padded first digest for the second hash.
  for (genvar gi = 0; gi < 16; gi++) begin : g_words
    if (gi == NONCE_WORD) begin : g_nonce
      assign chunk_word[gi] = (state_reg == LOAD2 && !first_reg) ? nonce_reg
                                                                 : data_to_hash[32*gi +: 32];
    end else begin : g_plain
      assign chunk_word[gi] = data_to_hash[32*gi +: 32];
    end
    if (gi < 8) begin : g_dig
      assign pad_word[gi] = digest_reg[255 - 32*gi -: 32];
    end else if (gi == 8) begin : g_start
      assign pad_word[gi] = PAD_START;
    end else if (gi == 15) begin : g_len
      assign pad_word[gi] = PAD_LEN;
    end else begin : g_zero
      assign pad_word[gi] = '0;
    end
  end

  // The nonce counts as a little-endian integer inside the header word
  assign nonce_int = bswap32(nonce_reg);
  assign nonce_inc = bswap32(nonce_int + 32'd1);
  assign hash_ok   = (bswap256(digest_reg) <= difficulty);

  // Main FSM: sequencing, schedule/working registers and registered outputs
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_reg       <= IDLE;
      round_reg       <= '0;
      for (int i = 0; i < 16; i++) w_reg[i] <= '0;
      work_reg        <= '0;
      mid_reg         <= IV;
      digest_reg      <= '0;
      nonce_reg       <= '0;
      first_reg       <= 1'b0;
      hash_select     <= 2'd0;
      valid_hash_flag <= 1'b0;
      valid_hash      <= '0;
      hash_done       <= 1'b0;
    end else if (quit_hash) begin
      state_reg       <= IDLE;
      hash_select     <= 2'd0;
      valid_hash_flag <= 1'b0;
      valid_hash      <= '0;
      hash_done       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (begin_hash) begin
            state_reg       <= LOAD1;
            hash_select     <= 2'd0;
            valid_hash_flag <= 1'b0;
            hash_done       <= 1'b0;
          end
        end
        LOAD1: begin
          w_reg     <= chunk_word;
          work_reg  <= IV;
          round_reg <= '0;
          first_reg <= 1'b1;
          state_reg <= RND1;
        end
        RND1, RND2, RND3: begin
          work_reg <= st_next;
          for (int i = 0; i < 15; i++) w_reg[i] <= w_reg[i+1];
          w_reg[15] <= w_new;
          round_reg <= round_reg + 6'd1;
          if (round_reg == 6'd63) begin
            hash_select <= 2'd0;
            state_reg   <= (state_reg == RND1) ? UPD1 :
                           (state_reg == RND2) ? UPD2 : UPD3;
          end
        end
        UPD1: begin
          mid_reg     <= add8(IV, work_reg);
          hash_select <= 2'd1;
          state_reg   <= LOAD2;
        end
        LOAD2: begin
          w_reg <= chunk_word;
          if (first_reg) nonce_reg <= data_to_hash[32*NONCE_WORD +: 32];
          first_reg <= 1'b0;
          work_reg  <= mid_reg;
          round_reg <= '0;
          state_reg <= RND2;
        end
        UPD2: begin
          digest_reg  <= add8(mid_reg, work_reg);
          hash_select <= 2'd2;
          state_reg   <= LOAD3;
        end
        LOAD3: begin
          w_reg     <= pad_word;
          work_reg  <= IV;
          round_reg <= '0;
          state_reg <= RND3;
        end
        UPD3: begin
          digest_reg <= add8(IV, work_reg);
          state_reg  <= CHECK;
        end
        CHECK: begin
          if (hash_ok) begin
            valid_hash      <= {digest_reg, nonce_reg};
            valid_hash_flag <= 1'b1;
            hash_done       <= 1'b1;
            state_reg       <= DONE;
          end else if (nonce_int == 32'hFFFFFFFF) begin
            valid_hash_flag <= 1'b0;
            hash_done       <= 1'b1;
            state_reg       <= DONE;
          end else begin
            nonce_reg   <= nonce_inc;
            hash_select <= 2'd1;
            state_reg   <= LOAD2;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hm_hash_engine.sv
// Scoreboard bench for hm_hash_engine using Bitcoin block 100000's header.
module tb_hm_hash_engine;

  logic         clk = 1'b0;
  logic         n_rst = 1'b1;
  logic         begin_hash = 1'b0;
  logic         quit_hash = 1'b0;
  logic [255:0] difficulty = '0;
  logic [511:0] data_to_hash;
  logic [1:0]   hash_select;
  logic         valid_hash_flag;
  logic [287:0] valid_hash;
  logic         hash_done;

  hm_hash_engine #(.NONCE_WORD(3)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .begin_hash      (begin_hash),
    .quit_hash       (quit_hash),
    .difficulty      (difficulty),
    .data_to_hash    (data_to_hash),
    .hash_select     (hash_select),
    .valid_hash_flag (valid_hash_flag),
    .valid_hash      (valid_hash),
    .hash_done       (hash_done)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] C1 [16] = '{
    32'h01000000, 32'h50120119, 32'h172a6104, 32'h21a6c301,
    32'h1dd330d9, 32'hdf07b636, 32'h16c2cc1f, 32'h1cd00200,
    32'h00000000, 32'h6657a925, 32'h2aacd5c0, 32'hb2940996,
    32'hecff9522, 32'h28c3067c, 32'hc38d4885, 32'hefb5a4ac
  };
  localparam logic [31:0] C2 [16] = '{
    32'h4247e9f3, 32'h37221b4d, 32'h4c86041b, 32'h0f2b5710,
    32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000280
  };
  localparam logic [255:0] DIGEST = 256'h06e533fd1ada86391f3f6c343204b0d278d4aaec1c0b20aa27ba030000000000;
  localparam logic [255:0] TARGET = {64'h000000000004864c, 192'h0};

  logic [31:0] nonce_in = 32'h0f2b5710;

  // Parent-side chunk multiplexer driven from hash_select
  always_comb begin
    data_to_hash = {16{32'ha5a55a5a}};
    if (hash_select == 2'd0) begin
      for (int i = 0; i < 16; i++) data_to_hash[32*i +: 32] = C1[i];
    end else if (hash_select == 2'd1) begin
      for (int i = 0; i < 16; i++) data_to_hash[32*i +: 32] = C2[i];
      data_to_hash[96 +: 32] = nonce_in;
    end
  end

  typedef struct {
    logic         flag;
    logic         chk_vh;
    logic [287:0] vh;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  logic done_prev = 1'b0;

  // Free-running cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Monitor: each rising hash_done pops and checks one expected result
  always @(negedge clk) begin
    exp_t e;
    done_prev <= hash_done;
    if (hash_done && !done_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 288'(hash_done), 288'(0));
      end else begin
        e = exp_q.pop_front();
        chk("flag", 288'(valid_hash_flag), 288'(e.flag));
        chk("latency", 288'(cyc - start_cyc), 288'(e.lat));
        if (e.chk_vh) chk("valid_hash", valid_hash, e.vh);
      end
    end
  end

  task automatic push_exp(input logic flag, input logic chk_vh, input logic [287:0] vh, input int lat);
    exp_t e;
    e.flag = flag; e.chk_vh = chk_vh; e.vh = vh; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic start_run(input logic [31:0] nonce, input logic [255:0] diff);
    @(negedge clk);
    nonce_in   = nonce;
    difficulty = diff;
    begin_hash = 1'b1;
    @(posedge clk);
    #1;
    start_cyc  = cyc;
    begin_hash = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("timeout_pending", 288'(exp_q.size()), 288'(0));
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_rel(input int rel);
    while (cyc - start_cyc < rel) @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_select"}, 288'(hash_select), 288'(0));
    chk({tag, "_flag"}, 288'(valid_hash_flag), 288'(0));
    chk({tag, "_done"}, 288'(hash_done), 288'(0));
    chk({tag, "_valid_hash"}, valid_hash, 288'(0));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    n_rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reference header, nonce found on the first attempt
    push_exp(1'b1, 1'b1, {DIGEST, 32'h0f2b5710}, 199);
    start_run(32'h0f2b5710, TARGET);
    wait_drain(400);

    // One failed attempt, then the incremented nonce succeeds
    push_exp(1'b1, 1'b1, {DIGEST, 32'h0f2b5710}, 332);
    start_run(32'h0e2b5710, TARGET);
    wait_drain(500);

    // Permissive target, with the chunk-select sequence checked
    push_exp(1'b1, 1'b1, {DIGEST, 32'h0f2b5710}, 199);
    start_run(32'h0f2b5710, {256{1'b1}});
    wait_rel(0);   chk("sel_load1", 288'(hash_select), 288'(0));
    wait_rel(66);  chk("sel_load2", 288'(hash_select), 288'(1));
    wait_rel(100); chk("sel_rnd2", 288'(hash_select), 288'(1));
    wait_rel(132); chk("sel_load3", 288'(hash_select), 288'(2));
    wait_rel(160); chk("sel_rnd3", 288'(hash_select), 288'(2));
    wait_rel(198); chk("sel_check", 288'(hash_select), 288'(0));
    wait_drain(400);

    // Exhaustion: last nonce, impossible target
    push_exp(1'b0, 1'b0, '0, 199);
    start_run(32'hffffffff, '0);
    wait_drain(400);

    // Quit mid-run clears outputs and produces no result
    start_run(32'h0e2b5710, TARGET);
    wait_rel(100);
    quit_hash = 1'b1;
    @(posedge clk);
    #1 quit_hash = 1'b0;
    @(negedge clk);
    chk_idle_outputs("quit");
    repeat (300) @(negedge clk);
    chk("quit_no_flag", 288'(valid_hash_flag), 288'(0));
    chk("quit_no_done", 288'(hash_done), 288'(0));

    // Asynchronous reset during RND2, then a clean rerun
    start_run(32'h0f2b5710, TARGET);
    wait_rel(100);
    chk("pre_reset_select", 288'(hash_select), 288'(1));
    #2 n_rst = 1'b1;
    #1 chk_idle_outputs("async_reset");
    @(negedge clk);
    n_rst = 1'b0;
    push_exp(1'b1, 1'b1, {DIGEST, 32'h0f2b5710}, 199);
    start_run(32'h0f2b5710, TARGET);
    wait_drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
